// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and length helpers for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [2:0] {S_OP, S_OPW, S_B1W, S_B2W, S_PRES} state_t;
  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;
  function automatic logic [1:0] norm_len(input logic [1:0] l);
    return (l == 2'd0) ? LEN1 : l;
  endfunction
endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches opcode plus 0-2 operand bytes and presents the bundle via valid/ready
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  len_opcode,
  input  logic [1:0]  len_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);
  state_t      state;
  logic [15:0] pc;
  logic [1:0]  len_now;
  logic        rd_op, rd_b1, rd_b2;
  always_comb begin
    len_now    = norm_len(len_in);
    len_opcode = (state == S_OPW) ? mem_rdata : 8'h00;
    rd_op      = state == S_OP;
    rd_b1      = state == S_OPW && len_now != LEN1;
    rd_b2      = state == S_B1W && inst_len == LEN3;
    // a redirect cycle issues no read, and reset forces the bus idle at once
    mem_rd     = rst_n && !redirect_valid && (rd_op || rd_b1 || rd_b2);
    mem_addr   = !mem_rd ? 16'h0000 : rd_op ? pc : rd_b1 ? pc + 16'd1 : pc + 16'd2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OP;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_opcode <= 8'h00;
      inst_op1    <= 8'h00;
      inst_op2    <= 8'h00;
      inst_len    <= 2'd0;
      inst_pc     <= 16'h0000;
    end else if (redirect_valid) begin
      state       <= S_OP;
      pc          <= redirect_pc;
      inst_valid  <= 1'b0;
      inst_opcode <= 8'h00;
      inst_op1    <= 8'h00;
      inst_op2    <= 8'h00;
      inst_len    <= 2'd0;
    end else begin
      case (state)
        S_OP: state <= S_OPW;
        S_OPW: begin
          inst_opcode <= mem_rdata;
          inst_len    <= len_now;
          inst_op1    <= 8'h00;
          inst_op2    <= 8'h00;
          if (len_now == LEN1) begin
            state      <= S_PRES;
            inst_valid <= 1'b1;
            inst_pc    <= pc;
            pc         <= pc + 16'd1;
          end else begin
            state <= S_B1W;
          end
        end
        S_B1W: begin
          inst_op1 <= mem_rdata;
          if (inst_len == LEN3) begin
            state <= S_B2W;
          end else begin
            state      <= S_PRES;
            inst_valid <= 1'b1;
            inst_pc    <= pc;
            pc         <= pc + {14'd0, inst_len};
          end
        end
        S_B2W: begin
          inst_op2   <= mem_rdata;
          state      <= S_PRES;
          inst_valid <= 1'b1;
          inst_pc    <= pc;
          pc         <= pc + {14'd0, inst_len};
        end
        S_PRES: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_OP;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for read addresses and presented bundles
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem [0:65535];
  logic        ready_a, ready_b, redir;
  logic [15:0] redir_pc;
  logic [15:0] mem_addr_a, mem_addr_b, inst_pc_a, inst_pc_b;
  logic        mem_rd_a, mem_rd_b, inst_valid_a, inst_valid_b;
  logic [7:0]  rdata_a, rdata_b, len_opcode_a, len_opcode_b;
  logic [7:0]  inst_opcode_a, inst_op1_a, inst_op2_a, inst_opcode_b, inst_op1_b, inst_op2_b;
  logic [1:0]  len_in_a, len_in_b, inst_len_a, inst_len_b;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_rd_a[$], exp_rd_b[$];
  logic [41:0] exp_bun_a[$], exp_bun_b[$];
  always #5 clk = ~clk;
  function automatic logic [1:0] lenf(input logic [7:0] op);
    return (op == 8'hEA) ? 2'd1 : (op == 8'hAD) ? 2'd3 : (op == 8'hA9) ? 2'd2 : 2'd0;
  endfunction
  function automatic logic [41:0] pk(input logic [7:0] op, o1, o2, input logic [1:0] l, input logic [15:0] pc);
    return {op, o1, o2, l, pc};
  endfunction
  assign len_in_a = lenf(len_opcode_a);
  assign len_in_b = lenf(len_opcode_b);
  always @(posedge clk) begin
    if (mem_rd_a) rdata_a <= mem[mem_addr_a];
    if (mem_rd_b) rdata_b <= mem[mem_addr_b];
  end
  inst_fetch_unit dut_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(rdata_a),
    .len_opcode(len_opcode_a), .len_in(len_in_a), .inst_valid(inst_valid_a), .inst_ready(ready_a),
    .inst_opcode(inst_opcode_a), .inst_op1(inst_op1_a), .inst_op2(inst_op2_a), .inst_len(inst_len_a),
    .inst_pc(inst_pc_a), .redirect_valid(redir), .redirect_pc(redir_pc)
  );
  inst_fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(rdata_b),
    .len_opcode(len_opcode_b), .len_in(len_in_b), .inst_valid(inst_valid_b), .inst_ready(ready_b),
    .inst_opcode(inst_opcode_b), .inst_op1(inst_op1_b), .inst_op2(inst_op2_b), .inst_len(inst_len_b),
    .inst_pc(inst_pc_b), .redirect_valid(1'b0), .redirect_pc(16'h0000)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_a && exp_rd_a.size() > 0) chk("rd_addr_a", mem_addr_a, exp_rd_a.pop_front());
      if (inst_valid_a && ready_a && !redir) begin
        if (exp_bun_a.size() == 0) chk("unexpected_bundle_a", {inst_opcode_a, inst_pc_a}, 0);
        else chk("bundle_a", pk(inst_opcode_a, inst_op1_a, inst_op2_a, inst_len_a, inst_pc_a), exp_bun_a.pop_front());
      end
      if (mem_rd_b && exp_rd_b.size() > 0) chk("rd_addr_b", mem_addr_b, exp_rd_b.pop_front());
      if (inst_valid_b && ready_b) begin
        if (exp_bun_b.size() == 0) chk("unexpected_bundle_b", {inst_opcode_b, inst_pc_b}, 0);
        else chk("bundle_b", pk(inst_opcode_b, inst_op1_b, inst_op2_b, inst_len_b, inst_pc_b), exp_bun_b.pop_front());
      end
    end
  end
  task automatic wait_valid_a(input logic [7:0] op);
    int n = 0;
    while (!(inst_valid_a && inst_opcode_a == op) && n < 40) begin
      @(posedge clk) #1;
      n++;
    end
    if (n >= 40) chk("timeout_valid_a", {8'h00, op}, {8'hFF, op});
  endtask
  task automatic wait_rd_a(input logic [15:0] a);
    int n = 0;
    while (!(mem_rd_a && mem_addr_a == a) && n < 40) begin
      @(posedge clk) #1;
      n++;
    end
    if (n >= 40) chk("timeout_rd_a", 0, a);
  endtask
  initial begin
    int n;
    rst_n = 1'b0; ready_a = 1'b1; ready_b = 1'b1; redir = 1'b0; redir_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hAD; mem[16'h0202] = 8'h34; mem[16'h0203] = 8'h12;
    mem[16'h0204] = 8'hA9; mem[16'h0205] = 8'h55; mem[16'h0207] = 8'hAD;
    mem[16'h0208] = 8'h11; mem[16'h0209] = 8'h22; mem[16'h0400] = 8'hA9; mem[16'h0401] = 8'h77;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h02; mem[16'h0001] = 8'hEA;
    foreach (exp_rd_a[i]) exp_rd_a.delete();
    exp_rd_a = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204, 16'h0205, 16'h0206,
                 16'h0207, 16'h0208, 16'h0400, 16'h0401, 16'h0400, 16'h0401, 16'h0402};
    exp_bun_a.push_back(pk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200));
    exp_bun_a.push_back(pk(8'hAD, 8'h34, 8'h12, 2'd3, 16'h0201));
    exp_bun_a.push_back(pk(8'hA9, 8'h55, 8'h00, 2'd2, 16'h0204));
    exp_bun_a.push_back(pk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0206));
    exp_bun_a.push_back(pk(8'hA9, 8'h77, 8'h00, 2'd2, 16'h0400));
    exp_bun_a.push_back(pk(8'h00, 8'h00, 8'h00, 2'd1, 16'h0402));
    exp_rd_b = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_bun_b.push_back(pk(8'hAD, 8'h01, 8'h02, 2'd3, 16'hFFFE));
    exp_bun_b.push_back(pk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0001));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", {mem_rd_a, mem_addr_a, len_opcode_a}, 0);
    chk("reset_bundle", {inst_valid_a, inst_opcode_a, inst_op1_a, inst_op2_a, inst_len_a, inst_pc_a}, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    #1 chk("first_read", {mem_rd_a, mem_addr_a}, {1'b1, 16'h0200});
    @(posedge clk) #1;
    chk("opw_len_opcode", {inst_valid_a, len_opcode_a}, {1'b0, 8'hEA});
    @(posedge clk) #1;
    chk("latency_len1", {inst_valid_a, inst_pc_a}, {1'b1, 16'h0200});
    wait_valid_a(8'hAD);
    @(posedge clk) #1 ready_a = 1'b0;
    wait_valid_a(8'hA9);
    for (int i = 0; i < 5; i++) begin
      chk("hold_stable", {inst_valid_a, mem_rd_a, inst_opcode_a, inst_op1_a, inst_op2_a, inst_len_a, inst_pc_a},
          {1'b1, 1'b0, 8'hA9, 8'h55, 8'h00, 2'd2, 16'h0204});
      @(posedge clk) #1;
    end
    ready_a = 1'b1;
    @(posedge clk) #1;
    chk("after_handshake", {inst_valid_a, mem_rd_a, mem_addr_a}, {1'b0, 1'b1, 16'h0206});
    wait_rd_a(16'h0208);
    @(posedge clk) #1;
    redir = 1'b1; redir_pc = 16'h0400;
    #1 chk("redirect_no_read", mem_rd_a, 1'b0);
    @(posedge clk) #1 redir = 1'b0;
    #1 chk("redirect_target", {inst_valid_a, mem_rd_a, mem_addr_a}, {1'b0, 1'b1, 16'h0400});
    wait_valid_a(8'hA9);
    redir = 1'b1;
    @(posedge clk) #1 redir = 1'b0;
    #1 chk("redirect_drop", {inst_valid_a, mem_rd_a, mem_addr_a}, {1'b0, 1'b1, 16'h0400});
    n = 0;
    while (exp_bun_a.size() > 0 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    ready_a = 1'b0;
    chk("drained_a", {exp_bun_a.size(), exp_rd_a.size()}, 0);
    wait_valid_a(8'h00);
    chk("drained_b", {exp_bun_b.size(), exp_rd_b.size()}, 0);
    chk("pre_reset_valid", {inst_valid_a, inst_pc_a}, {1'b1, 16'h0403});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {inst_valid_a, mem_rd_a, mem_addr_a, inst_opcode_a, inst_pc_a}, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
  initial begin
    int n = 0;
    @(posedge rst_n);
    while (exp_bun_b.size() > 0 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    ready_b = 1'b0;
  end
endmodule
